// File: rtl/mul_pkg.sv
// Shared definitions for the multiplier resolve stage: widths, FSM states
// and the in_op encoding.
package mul_pkg;

  localparam int RES_W = 64;
  localparam int HI_W  = 32;
  localparam int LO_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_ACC  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Operation encoding; OP_RSVD behaves exactly like OP_MULT.
  typedef enum logic [1:0] {
    OP_MULT = 2'b00,
    OP_MADD = 2'b01,
    OP_MSUB = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

endpackage

// File: rtl/cpa64.sv
// 64-bit carry-propagate adder: sum_o = a_i + b_i, or a_i - b_i when sub_i
// is set (two's complement: invert b and inject a carry-in of one).
module cpa64 (
  input  logic [63:0] a_i,
  input  logic [63:0] b_i,
  input  logic        sub_i,
  output logic [63:0] sum_o
);

  logic [63:0] b_eff;

  assign b_eff = sub_i ? ~b_i : b_i;
  assign sum_o = a_i + b_eff + {63'd0, sub_i};

endmodule

// File: rtl/mul_resolve.sv
// Multiplier resolve stage: collapses the carry-save pair from the
// compression tree into the final product, optionally accumulates it into
// {HI,LO}, and hands the result to writeback with a valid/ready handshake.
// Optional feature macro: MUL_RESOLVE_MADD_EN enables MADD/MSUB (ACC state
// and the accumulate adder); without it every operation is a plain MULT.
module mul_resolve #(
  parameter int RES_W = mul_pkg::RES_W
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [RES_W-1:0]   in_sum,
  input  logic [RES_W-1:0]   in_carry,
  input  logic [1:0]         in_op,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [RES_W-1:0]   out_res,
  output logic [RES_W/2-1:0] hi,
  output logic [RES_W/2-1:0] lo,
  output logic               busy
);

  import mul_pkg::*;

  state_e           state_q, state_d;
  logic [RES_W-1:0] sum_q, carry_q;
  logic [RES_W-1:0] res_q, res_d;
  logic [RES_W-1:0] hilo_q;
  logic [RES_W-1:0] add_res;
  logic [RES_W-1:0] acc_res;
  logic             is_acc;
  logic             accept;
  logic             load_res;

  // A flush in the same cycle blocks any new transfer, including in IDLE.
  assign in_ready = !flush &&
                    ((state_q == ST_IDLE) || (state_q == ST_DONE && out_ready));
  assign accept   = in_valid && in_ready;

  // Final carry-propagate add of the carry-save pair (ADD state).
  cpa64 u_add (
    .a_i   (sum_q),
    .b_i   (carry_q),
    .sub_i (1'b0),
    .sum_o (add_res)
  );

`ifdef MUL_RESOLVE_MADD_EN
  op_e              op_q;
  logic [RES_W-1:0] prod_q;

  assign is_acc = (op_q == OP_MADD) || (op_q == OP_MSUB);

  // Accumulate {HI,LO} with the registered product (ACC state).
  cpa64 u_acc (
    .a_i   (hilo_q),
    .b_i   (prod_q),
    .sub_i (op_q == OP_MSUB),
    .sum_o (acc_res)
  );

  // Operation latch on accept and product register filled during ADD.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_q   <= OP_MULT;
      prod_q <= '0;
    end else begin
      if (accept)
        op_q <= op_e'(in_op);
      if (state_q == ST_ADD)
        prod_q <= add_res;
    end
  end
`else
  // in_op carries no meaning in this build; fold it into a sink signal.
  logic unused_op;
  assign unused_op = ^in_op;
  assign is_acc    = 1'b0;
  assign acc_res   = '0;
`endif

  // Next-state logic plus result-load select.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d  = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_ADD;
      ST_ADD: begin
        if (flush)       state_d = ST_IDLE;
        else if (is_acc) state_d = ST_ACC;
        else             state_d = ST_DONE;
      end
      ST_ACC:  state_d = flush ? ST_IDLE : ST_DONE;
      ST_DONE: begin
        if (flush)          state_d = ST_IDLE;
        else if (out_ready) state_d = accept ? ST_ADD : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // The result and {HI,LO} are written only on the edge that enters DONE.
    load_res = (state_d == ST_DONE) && (state_q != ST_DONE);
    res_d    = (state_q == ST_ACC) ? acc_res : add_res;
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Stage registers capture the carry-save pair on accept.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sum_q   <= '0;
      carry_q <= '0;
    end else if (accept) begin
      sum_q   <= in_sum;
      carry_q <= in_carry;
    end
  end

  // Result and architectural {HI,LO}, updated together on DONE entry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      res_q  <= '0;
      hilo_q <= '0;
    end else if (load_res) begin
      res_q  <= res_d;
      hilo_q <= res_d;
    end
  end

  assign out_valid = (state_q == ST_DONE);
  assign out_res   = res_q;
  assign hi        = hilo_q[RES_W-1 -: HI_W];
  assign lo        = hilo_q[LO_W-1:0];
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mul_resolve.sv
// Self-checking bench for mul_resolve: a transaction-level model (latency,
// arithmetic on {HI,LO}) checked every cycle, plus literal directed cases.
// Honours MUL_RESOLVE_MADD_EN the same way the design does.
module tb_mul_resolve;
  import mul_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_sum;
  logic [63:0] in_carry;
  logic [1:0]  in_op;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_res;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;

  int total = 0;
  int bad   = 0;

  mul_resolve #(.RES_W(64)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_carry  (in_carry),
    .in_op     (in_op),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_pend  = 1'b0;
  bit          m_valid = 1'b0;
  logic [63:0] m_res   = '0;
  logic [63:0] m_out   = '0;
  logic [63:0] m_hilo  = '0;
  int          m_due   = 0;
  int          cyc     = 0;
  bit          m_acc;

  function automatic int lat_of(input logic [1:0] op);
`ifdef MUL_RESOLVE_MADD_EN
    return (op == OP_MADD || op == OP_MSUB) ? 3 : 2;
`else
    return 2;
`endif
  endfunction

  function automatic logic [63:0] calc(input logic [1:0] op, input logic [63:0] s,
                                       input logic [63:0] c, input logic [63:0] acc);
    logic [63:0] p;
    p = s + c;
`ifdef MUL_RESOLVE_MADD_EN
    if (op == OP_MADD) return acc + p;
    if (op == OP_MSUB) return acc - p;
`endif
    return p;
  endfunction

  function automatic bit exp_ready();
    return !flush && (!(m_pend || m_valid) || (m_valid && out_ready));
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_pend  = 1'b0;
      m_valid = 1'b0;
      m_out   = '0;
      m_hilo  = '0;
    end else begin
      m_acc = in_valid && exp_ready();
      if (flush) begin
        m_pend  = 1'b0;
        m_valid = 1'b0;
      end else begin
        if (m_valid && out_ready) m_valid = 1'b0;
        if (m_pend && (cyc + 1 == m_due)) begin
          m_valid = 1'b1;
          m_out   = m_res;
          m_hilo  = m_res;
          m_pend  = 1'b0;
        end
        if (m_acc) begin
          m_pend = 1'b1;
          m_due  = cyc + lat_of(in_op);
          m_res  = calc(in_op, in_sum, in_carry, m_hilo);
        end
      end
    end
    if (resetn) cyc++;
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (resetn) begin
      check("busy",      {63'd0, busy},      {63'd0, m_pend || m_valid});
      check("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
      check("in_ready",  {63'd0, in_ready},  {63'd0, exp_ready()});
      check("hi",        {32'd0, hi},        {32'd0, m_hilo[63:32]});
      check("lo",        {32'd0, lo},        {32'd0, m_hilo[31:0]});
      if (m_valid) check("out_res", out_res, m_out);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a pair until it is taken; returns one cycle after the accept edge.
  task automatic send(input logic [1:0] op, input logic [63:0] s, input logic [63:0] c);
    bit got;
    got      = 1'b0;
    in_valid = 1'b1;
    in_op    = op;
    in_sum   = s;
    in_carry = c;
    for (int k = 0; k < 50 && !got; k++) begin
      #1;
      got = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!got) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    if (!out_valid) check("wait_valid_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n;
    logic [63:0] held;
    resetn    = 1'b0;
    in_valid  = 1'b0;
    in_sum    = '0;
    in_carry  = '0;
    in_op     = OP_MULT;
    flush     = 1'b0;
    out_ready = 1'b1;

    #3;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_res",   out_res,            64'd0);
    check("rst_hi",        {32'd0, hi},        64'd0);
    check("rst_lo",        {32'd0, lo},        64'd0);
    check("rst_busy",      {63'd0, busy},      64'd0);
    #9 resetn = 1'b1;
    step();

    // MULT carry across the HI/LO boundary.
    send(OP_MULT, 64'h0000_0000_FFFF_FFFF, 64'h1);
    wait_valid(n);
    check("mult_lat",  n,            64'd1);
    check("mult_res",  out_res,      64'h1_0000_0000);
    check("mult_hi",   {32'd0, hi},  64'd1);
    check("mult_lo",   {32'd0, lo},  64'd0);
    step();

    // MULT all ones.
    send(OP_MULT, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
    wait_valid(n);
    check("ones_res", out_res,     64'hFFFF_FFFF_FFFF_FFFF);
    check("ones_hi",  {32'd0, hi}, 64'hFFFF_FFFF);
    check("ones_lo",  {32'd0, lo}, 64'hFFFF_FFFF);
    step();

    // Accumulate sequence: {HI,LO}=5, MADD 3, MSUB 10.
    send(OP_MULT, 64'd5, 64'd0);
    wait_valid(n);
    step();
    send(OP_MADD, 64'd1, 64'd2);
    wait_valid(n);
`ifdef MUL_RESOLVE_MADD_EN
    check("madd_lat", n,            64'd2);
    check("madd_lo",  {32'd0, lo},  64'd8);
    check("madd_hi",  {32'd0, hi},  64'd0);
`else
    check("madd_as_mult_lat", n,           64'd1);
    check("madd_as_mult_lo",  {32'd0, lo}, 64'd3);
`endif
    step();
    send(OP_MSUB, 64'd4, 64'd6);
    wait_valid(n);
`ifdef MUL_RESOLVE_MADD_EN
    check("msub_hi", {32'd0, hi}, 64'hFFFF_FFFF);
    check("msub_lo", {32'd0, lo}, 64'hFFFF_FFFE);
`else
    check("msub_as_mult_lo", {32'd0, lo}, 64'd10);
`endif
    step();

    // Back-pressure hold, then back-to-back accept.
    out_ready = 1'b0;
    send(OP_MULT, 64'h1234, 64'h1);
    wait_valid(n);
    held = out_res;
    check("hold_first", held, 64'h1235);
    for (int k = 0; k < 5; k++) begin
      step();
      check("hold_valid", {63'd0, out_valid}, 64'd1);
      check("hold_res",   out_res,            64'h1235);
      check("hold_ready", {63'd0, in_ready},  64'd0);
    end
    in_valid  = 1'b1;
    in_op     = OP_MULT;
    in_sum    = 64'd7;
    in_carry  = 64'd1;
    out_ready = 1'b1;
    #1;
    check("b2b_ready", {63'd0, in_ready}, 64'd1);
    step();
    in_valid = 1'b0;
    check("b2b_busy",  {63'd0, busy},      64'd1);
    check("b2b_valid", {63'd0, out_valid}, 64'd0);
    wait_valid(n);
    check("b2b_lat", n,       64'd1);
    check("b2b_res", out_res, 64'd8);
    step();

    // Flush in ADD: nothing completes, {HI,LO} stays at 8.
    send(OP_MULT, 64'd100, 64'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fadd_busy",  {63'd0, busy},      64'd0);
    check("fadd_valid", {63'd0, out_valid}, 64'd0);
    check("fadd_lo",    {32'd0, lo},        64'd8);
    step();
    step();
    check("fadd_quiet", {63'd0, out_valid}, 64'd0);

    // Flush in DONE with a competing pair: output drops, no accept.
    out_ready = 1'b0;
    send(OP_MULT, 64'd40, 64'd2);
    wait_valid(n);
    flush    = 1'b1;
    in_valid = 1'b1;
    step();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("fdone_valid", {63'd0, out_valid}, 64'd0);
    check("fdone_busy",  {63'd0, busy},      64'd0);
    check("fdone_lo",    {32'd0, lo},        64'd42);
    step();

    // Reset mid-operation (ACC when accumulate is built in, ADD otherwise).
    send(OP_MADD, 64'd2, 64'd3);
`ifdef MUL_RESOLVE_MADD_EN
    step();
`endif
    #2 resetn = 1'b0;
    #1;
    check("mrst_valid", {63'd0, out_valid}, 64'd0);
    check("mrst_res",   out_res,            64'd0);
    check("mrst_hi",    {32'd0, hi},        64'd0);
    check("mrst_lo",    {32'd0, lo},        64'd0);
    check("mrst_busy",  {63'd0, busy},      64'd0);
    #2 resetn = 1'b1;
    send(OP_MULT, 64'd10, 64'd20);
    wait_valid(n);
    check("post_rst_lat", n,       64'd1);
    check("post_rst_res", out_res, 64'd30);
    step();

    // Randomised traffic checked by the model every cycle.
    for (int k = 0; k < 800; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_op     = 2'($urandom_range(0, 3));
      in_sum    = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
      in_carry  = ($urandom_range(0, 7) == 0) ? 64'd1 : {$urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      step();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) step();
    check("drain_idle", {63'd0, busy}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
